// File: rtl/music_beat_sequencer_pkg.sv
// Shared types and defaults for the music beat sequencer.
// Optional build macro: MUSIC_SEEK_EN (adds seek / seek_beat).
package music_pkg;

  localparam int DEF_BEAT_W = 12;
  localparam int DEF_DIV_W  = 24;

  typedef enum logic [1:0] {
    MODE_LOOP     = 2'd0,
    MODE_ONESHOT  = 2'd1,
    MODE_PINGPONG = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // The reserved mode code 3 plays as a loop.
  function automatic mode_t decode_mode(input logic [1:0] m);
    mode_t r;
    case (m)
      2'd1:    r = MODE_ONESHOT;
      2'd2:    r = MODE_PINGPONG;
      default: r = MODE_LOOP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/music_beat_sequencer_if.sv
// Control/status bundle between the player FSM (master) and the beat
// sequencer (slave). Optional build macro: MUSIC_SEEK_EN.
//
// Signalling: start, stop and seek are single-cycle pulses sampled on the
// rising clock edge; pause is a level. There is no valid/ready handshake:
// every pulse is consumed on the edge where it is seen, with priority
// stop > start > seek > pause. Outputs are registered; beat_tick and wrap
// are one-cycle pulses aligned with the ibeat update they describe.
interface music_beat_sequencer_if
  import music_pkg::*;
#(
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int DIV_W  = DEF_DIV_W
);
  logic              start;
  logic              stop;
  logic              pause;
  logic [1:0]        mode;
  logic [BEAT_W-1:0] len;
  logic [DIV_W-1:0]  div;
`ifdef MUSIC_SEEK_EN
  logic              seek;
  logic [BEAT_W-1:0] seek_beat;
`endif
  logic [BEAT_W-1:0] ibeat;
  logic              beat_tick;
  logic              wrap;
  logic              busy;
  logic              done;
  logic              dir;
  seq_state_t        dbg_state;

  modport master (
    output start, stop, pause, mode, len, div,
`ifdef MUSIC_SEEK_EN
    output seek, seek_beat,
`endif
    input  ibeat, beat_tick, wrap, busy, done, dir, dbg_state
  );

  modport slave (
    input  start, stop, pause, mode, len, div,
`ifdef MUSIC_SEEK_EN
    input  seek, seek_beat,
`endif
    output ibeat, beat_tick, wrap, busy, done, dir, dbg_state
  );
endinterface

// File: rtl/music_beat_sequencer_prescaler.sv
// Tempo prescaler: counts clocks within a beat and flags the last one.
module beat_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic             o_tick
);
  logic [DIV_W-1:0] r_div_l;
  logic [DIV_W-1:0] r_pcnt;

  // Tick on the last clock of the beat while counting is enabled.
  assign o_tick = i_enable && (r_pcnt == (r_div_l - DIV_W'(1)));

  // Latch the divider on load (0 means 1); count or clear the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_l <= DIV_W'(1);
      r_pcnt  <= '0;
    end else begin
      if (i_load) r_div_l <= (i_div == '0) ? DIV_W'(1) : i_div;
      if (i_clear)       r_pcnt <= '0;
      else if (i_enable) r_pcnt <= o_tick ? '0 : r_pcnt + DIV_W'(1);
    end
  end
endmodule

// File: rtl/music_beat_sequencer.sv
// Beat-index generator: tempo prescaler, start/stop/pause control and
// loop / one-shot / ping-pong play modes over a run-time song length.
// Optional build macro: MUSIC_SEEK_EN (seek to a beat while playing).
module music_beat_sequencer
  import music_pkg::*;
#(
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int DIV_W  = DEF_DIV_W
) (
  input logic                  clk,
  input logic                  rst_n,
  music_beat_sequencer_if.slave bus
);
  seq_state_t        r_state, w_state_n;
  mode_t             r_mode_l;
  logic [BEAT_W-1:0] r_len_l, r_ibeat, w_ibeat_n, w_len_eff, w_last_beat;
  logic [BEAT_W:0]   w_next_up;
  logic              r_dir, w_dir_n, r_tick, w_tick_n, r_wrap, w_wrap_n;
  logic              r_busy, r_done;
  logic              w_at_end, w_seek_hit, w_pre_load, w_pre_clear;
  logic              w_pre_en, w_pre_tick;

  // Lengths of 0 and 1 both mean a single beat; the end test uses one
  // extra bit so the largest length cannot overflow ibeat+1.
  assign w_len_eff   = (r_len_l <= BEAT_W'(1)) ? BEAT_W'(1) : r_len_l;
  assign w_last_beat = w_len_eff - BEAT_W'(1);
  assign w_next_up   = {1'b0, r_ibeat} + (BEAT_W + 1)'(1);
  assign w_at_end    = !(w_next_up < {1'b0, w_len_eff});

`ifdef MUSIC_SEEK_EN
  assign w_seek_hit = bus.seek && ((r_state == RUN) || (r_state == PAUSE));
`else
  assign w_seek_hit = 1'b0;
`endif

  assign w_pre_load  = bus.start && !bus.stop;
  assign w_pre_clear = bus.stop || bus.start || w_seek_hit;
  assign w_pre_en    = (r_state == RUN) && !bus.pause && !w_pre_clear;

  beat_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_pre_load),
    .i_div    (bus.div),
    .i_clear  (w_pre_clear),
    .i_enable (w_pre_en),
    .o_tick   (w_pre_tick)
  );

  // Next state, beat position, direction and pulses.
  always_comb begin
    w_state_n = r_state;
    w_ibeat_n = r_ibeat;
    w_dir_n   = r_dir;
    w_tick_n  = 1'b0;
    w_wrap_n  = 1'b0;
    if (bus.stop) begin
      w_state_n = IDLE;
      w_ibeat_n = '0;
      w_dir_n   = 1'b1;
    end else if (bus.start) begin
      w_state_n = RUN;
      w_ibeat_n = '0;
      w_dir_n   = 1'b1;
    end else if (w_seek_hit) begin
`ifdef MUSIC_SEEK_EN
      w_ibeat_n = (bus.seek_beat > w_last_beat) ? w_last_beat : bus.seek_beat;
`endif
    end else begin
      case (r_state)
        RUN: begin
          if (bus.pause) begin
            w_state_n = PAUSE;
          end else if (w_pre_tick) begin
            case (r_mode_l)
              MODE_ONESHOT: begin
                if (w_at_end) begin
                  w_state_n = DONE;
                end else begin
                  w_ibeat_n = w_next_up[BEAT_W-1:0];
                  w_tick_n  = 1'b1;
                end
              end
              MODE_PINGPONG: begin
                w_tick_n = 1'b1;
                if (w_len_eff == BEAT_W'(1)) begin
                  w_ibeat_n = '0;
                  w_dir_n   = 1'b1;
                end else if (r_dir) begin
                  if (r_ibeat == w_last_beat) begin
                    w_dir_n   = 1'b0;
                    w_ibeat_n = w_len_eff - BEAT_W'(2);
                  end else begin
                    w_ibeat_n = r_ibeat + BEAT_W'(1);
                  end
                end else if (r_ibeat == '0) begin
                  w_dir_n   = 1'b1;
                  w_ibeat_n = BEAT_W'(1);
                  w_wrap_n  = 1'b1;
                end else begin
                  w_ibeat_n = r_ibeat - BEAT_W'(1);
                end
              end
              default: begin
                w_tick_n = 1'b1;
                if (w_at_end) begin
                  w_ibeat_n = '0;
                  w_wrap_n  = 1'b1;
                end else begin
                  w_ibeat_n = w_next_up[BEAT_W-1:0];
                end
              end
            endcase
          end
        end
        PAUSE:   if (!bus.pause) w_state_n = RUN;
        default: ;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ibeat <= '0;
      r_dir   <= 1'b1;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ibeat <= w_ibeat_n;
      r_dir   <= w_dir_n;
      r_tick  <= w_tick_n;
      r_wrap  <= w_wrap_n;
      r_busy  <= (w_state_n == RUN) || (w_state_n == PAUSE);
      r_done  <= (w_state_n == DONE);
    end
  end

  // Song configuration is captured only on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_l  <= BEAT_W'(1);
      r_mode_l <= MODE_LOOP;
    end else if (w_pre_load) begin
      r_len_l  <= bus.len;
      r_mode_l <= decode_mode(bus.mode);
    end
  end

  assign bus.ibeat     = r_ibeat;
  assign bus.beat_tick = r_tick;
  assign bus.wrap      = r_wrap;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dir       = r_dir;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_music_beat_sequencer.sv
// Self-checking bench for music_beat_sequencer: directed scenarios plus a
// randomized phase, compared every cycle against a tick-count reference.
module tb_music_beat_sequencer;
  import music_pkg::*;

  localparam int BEAT_W = 12;
  localparam int DIV_W  = 24;
  localparam int EXP_W  = BEAT_W + 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  music_beat_sequencer_if #(.BEAT_W(BEAT_W), .DIV_W(DIV_W)) bus ();

  music_beat_sequencer #(.BEAT_W(BEAT_W), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position is derived from the number of beats played since start (m_k)
  // rather than from a stored beat register.
  int m_st;      // 0 idle, 1 run, 2 pause, 3 done
  int m_mode;    // 0 loop, 1 one-shot, 2 ping-pong
  int m_len;     // effective length (>=1)
  int m_div;     // effective clocks per beat (>=1)
  int m_cnt;     // clocks already spent in the current beat
  int m_k;       // beats advanced since start
  bit m_tick, m_wrap;

  task automatic model_reset();
    m_st = 0; m_mode = 0; m_len = 1; m_div = 1;
    m_cnt = 0; m_k = 0; m_tick = 0; m_wrap = 0;
  endtask

  function automatic int exp_beat();
    int p, r;
    if (m_mode == 0) return m_k % m_len;
    if (m_mode == 1) return m_k;
    if (m_len == 1) return 0;
    p = 2 * (m_len - 1);
    r = m_k % p;
    return (r <= m_len - 1) ? r : p - r;
  endfunction

  function automatic bit exp_dir();
    int p, r;
    if (m_mode != 2 || m_len == 1) return 1'b1;
    p = 2 * (m_len - 1);
    r = m_k % p;
    if (r == 0 && m_k > 0) return 1'b0;
    return (r <= m_len - 1);
  endfunction

  task automatic model_advance();
    int p;
    if (m_mode == 1) begin
      if (m_k + 1 >= m_len) m_st = 3;
      else begin m_k++; m_tick = 1; end
    end else if (m_mode == 0) begin
      m_k++; m_tick = 1;
      if (m_k % m_len == 0) m_wrap = 1;
    end else begin
      m_k++; m_tick = 1;
      if (m_len > 1) begin
        p = 2 * (m_len - 1);
        if (m_k > p && m_k % p == 1) m_wrap = 1;
      end
    end
  endtask

  task automatic model_step();
    m_tick = 0; m_wrap = 0;
    if (bus.stop) begin
      m_st = 0; m_cnt = 0; m_k = 0;
    end else if (bus.start) begin
      m_st   = 1;
      m_mode = (bus.mode == 2'd2) ? 2 : (bus.mode == 2'd1) ? 1 : 0;
      m_len  = (bus.len <= 1) ? 1 : int'(bus.len);
      m_div  = (bus.div == 0) ? 1 : int'(bus.div);
      m_cnt  = 0; m_k = 0;
    end else if (m_st == 1 && bus.pause) begin
      m_st = 2;
    end else if (m_st == 2 && !bus.pause) begin
      m_st = 1;
    end else if (m_st == 1) begin
      m_cnt++;
      if (m_cnt == m_div) begin
        m_cnt = 0;
        model_advance();
      end
    end
  endtask

  function automatic logic [EXP_W-1:0] exp_vec();
    logic [BEAT_W-1:0] b;
    b = BEAT_W'(exp_beat());
    return {b, m_tick, m_wrap, (m_st == 1 || m_st == 2), (m_st == 3), exp_dir()};
  endfunction

  task automatic cmp_outputs(input logic [EXP_W-1:0] e);
    check("ibeat",     32'(bus.ibeat),     32'(e[EXP_W-1:5]));
    check("beat_tick", 32'(bus.beat_tick), 32'(e[4]));
    check("wrap",      32'(bus.wrap),      32'(e[3]));
    check("busy",      32'(bus.busy),      32'(e[2]));
    check("done",      32'(bus.done),      32'(e[1]));
    check("dir",       32'(bus.dir),       32'(e[0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick_cycle();
    logic [EXP_W-1:0] e;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    exp_q.push_back(exp_vec());
    @(negedge clk);
    e = exp_q.pop_front();
    cmp_outputs(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  task automatic do_start(input logic [1:0] md, input int ln, input int dv);
    bus.mode  = md;
    bus.len   = BEAT_W'(ln);
    bus.div   = DIV_W'(dv);
    bus.start = 1'b1;
    tick_cycle();
    bus.start = 1'b0;
  endtask

  task automatic wait_beat(input string tag, input int target);
    for (int i = 0; i < 200 && exp_beat() != target; i++) tick_cycle();
    check(tag, 32'(bus.ibeat), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    bus.mode = 2'd0; bus.len = '0; bus.div = '0;
`ifdef MUSIC_SEEK_EN
    bus.seek = 1'b0; bus.seek_beat = '0;
`endif
    model_reset();
    run(3);                       // reset values while rst_n low
    rst_n = 1'b1;
    bus.pause = 1'b1;             // ignored in IDLE
    run(4);
    bus.pause = 1'b0;

    do_start(2'd0, 4, 3);  run(30);   // loop, wrap on 3->0
    do_start(2'd1, 3, 1);  run(10);   // one-shot to DONE
    bus.pause = 1'b1; run(2); bus.pause = 1'b0;  // ignored in DONE
    do_start(2'd1, 3, 1);  run(6);    // restart from DONE
    do_start(2'd2, 4, 1);  run(20);   // ping-pong
    do_start(2'd2, 2, 2);  run(14);   // ping-pong, shortest bounce
    do_start(2'd2, 1, 1);  run(5);    // ping-pong, single beat
    do_start(2'd3, 5, 1);  run(12);   // reserved mode plays as loop

    // pause and resume with div=2
    do_start(2'd0, 8, 2);
    wait_beat("reach_beat5", 5);
    bus.pause = 1'b1; run(10);
    bus.pause = 1'b0; run(12);
    bus.stop = 1'b1; bus.start = 1'b1; tick_cycle();
    bus.stop = 1'b0; bus.start = 1'b0; run(4);

    do_start(2'd0, 0, 0);  run(8);    // len=0 div=0: tick+wrap every clock
    do_start(2'd1, 1, 1);  run(4);    // one-shot single beat

    // full-width length, with config changes mid-run
    do_start(2'd0, 4095, 1);
    run(100);
    bus.len = BEAT_W'(3); bus.mode = 2'd1; bus.div = DIV_W'(5);
    run(4100);

    // async reset mid-pause at beat 6
    do_start(2'd0, 10, 1);
    wait_beat("reach_beat6", 6);
    bus.pause = 1'b1; run(3);
    #2 rst_n = 1'b0;
    #1 model_reset();
    cmp_outputs(exp_vec());
    run(2);
    rst_n = 1'b1;
    bus.pause = 1'b0;
    run(6);                       // stays idle

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 99) < 3);
      bus.stop  = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 6) bus.pause = ~bus.pause;
      bus.mode  = 2'($urandom_range(0, 3));
      bus.len   = BEAT_W'($urandom_range(0, 9));
      bus.div   = DIV_W'($urandom_range(0, 4));
      tick_cycle();
    end
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    run(3);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    n_err++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/music_beat_sequencer.md
Name: music_beat_sequencer

Overview:
- Parametrised beat-index generator for the music player; drives the note/tone lookup with the current beat number.
- Adds a tempo prescaler, start/stop/pause control, loop, one-shot and ping-pong play modes, and run-time song length.
- Sits between the top-level player FSM/buttons and the note ROM. Replaces the fixed-length free-running beat counter.

Parameters:
- BEAT_W, 12, width of beat index and length.
- DIV_W, 24, width of tempo divider (clocks per beat).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: latch config, restart from beat 0.
- stop  in  1  pulse: return to idle, beat 0.
- pause  in  1  level: hold position while high.
- mode  in  2  0=loop, 1=one-shot, 2=ping-pong, 3=reserved (treated as loop).
- len  in  BEAT_W  song length in beats; valid beats 0..len-1.
- div  in  DIV_W  clocks per beat; 0 treated as 1.
- ibeat  out  BEAT_W  current beat index.
- beat_tick  out  1  one-cycle pulse, coincident with each ibeat update.
- wrap  out  1  one-cycle pulse at loop restart / ping-pong bottom turn.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  high in DONE (one-shot finished).
- dir  out  1  1=counting up, 0=down (ping-pong only).

Behaviour:
- Reset (rst_n low, async): state IDLE; ibeat=0, pcnt=0, dir=1; beat_tick, wrap, busy and done all 0. Latched config is cleared to len=1, div=1, mode=loop.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Priority per cycle is stop > start > pause.
  - stop from any state: go to IDLE, ibeat=0, pcnt=0, dir=1.
  - start from any state: latch len/mode/div, ibeat=0, pcnt=0, dir=1, go to RUN. busy=1 from the next edge.
  - RUN with pause=1: go to PAUSE; ibeat and pcnt frozen. PAUSE with pause=0: resume RUN with the prescaler continuing from the frozen pcnt.
- Config changes while busy are ignored until the next start.
- Prescaler (RUN only):
  - pcnt counts 0..div_l-1. When pcnt==div_l-1, pcnt returns to 0 and a tick is issued.
  - First tick comes div_l clocks after start. div_l=1 gives a tick every clock.
- Length rule: len_l<=1 is treated as 1, so ibeat stays 0.
  - Loop mode with len_l=1: beat_tick and wrap pulse on every tick.
  - One-shot mode with len_l=1: DONE on the first tick.
- Compare ibeat+1 against len_l in BEAT_W+1 bits so that len=2^BEAT_W-1 does not overflow.
- On each tick:
  - Loop: if ibeat+1<len_l then ibeat+1, else ibeat=0 and wrap=1.
  - One-shot: if ibeat+1<len_l then ibeat+1. Otherwise go to DONE with ibeat held at len_l-1 and no further ticks. beat_tick is not asserted on the DONE transition.
  - Ping-pong, dir=1: at len_l-1 set dir=0, ibeat=len_l-2; else ibeat+1.
  - Ping-pong, dir=0: at 0 set dir=1, ibeat=1, wrap=1; else ibeat-1.
  - Ping-pong with len_l=1: ibeat stays 0, dir stays 1, no wrap.
- DONE: done=1, busy=0. Exits only on start (to RUN) or stop (to IDLE). pause is ignored in IDLE and DONE.
- Reset asserted mid-play aborts immediately to reset values. There is no pending tick after release.

Optional Feature:
- Macro MUSIC_SEEK_EN.
- Defined:
  - Adds input seek (1, pulse) and input seek_beat (BEAT_W).
  - In RUN or PAUSE, seek sets ibeat=min(seek_beat, len_l-1) and pcnt=0; dir and state are unchanged.
  - Priority is below stop/start and above tick; beat_tick is not pulsed on a seek.
  - seek in IDLE or DONE is ignored.
- Not defined: the ports are absent and there is no seek logic.

Decomposition:
- Shared package music_pkg:
  - mode_t enum (MODE_LOOP, MODE_ONESHOT, MODE_PINGPONG).
  - seq_state_t enum (IDLE, RUN, PAUSE, DONE).
  - Default constants DEF_BEAT_W=12, DEF_DIV_W=24.
- Sub-module beat_prescaler: holds pcnt and div_l. Inputs are clear and enable; output is the tick. Instantiated once.

Test Plan:
- Loop: len=4, div=3, start → ibeat 0,1,2,3,0,… changing every 3 clocks. wrap pulses on each 3→0. First tick 3 clocks after start.
- One-shot: len=3, div=1 → ibeat 0,1,2 then DONE. done=1, busy=0, ibeat holds 2. A later start restarts from 0.
- Ping-pong: len=4, div=1 → sequence 0,1,2,3,2,1,0,1,…. dir falls at 3 and rises at 0, with wrap at the 0→1 turn.
- Pause/stop: len=8, div=2. Pause high at ibeat=5 for 10 clocks → ibeat stays 5 and resumes with the same prescaler phase. stop with simultaneous start → IDLE, ibeat=0.
- Boundaries:
  - div=0, len=0, loop mode → ibeat=0 with beat_tick and wrap every clock.
  - len=4095, div=1 → wraps 4094→0 with no overflow.
  - Changing len mid-run has no effect until the next start.
- Reset: rst_n pulled low while ibeat=6 mid-pause → all outputs reset asynchronously. After release, the block stays IDLE until start.
